fir_sample_loader: RTL and testbench
====================================

// Module: fir_sample_loader
// PURPOSE
//  Writer side of the FIR sample memory. Accepts a valid/ready byte stream and writes it to memory port A
//  (addr_a/we_a/data_in_a), optionally zero-pads the unused addresses, then runs fir_top.
//  It pulses start, waits for done and reports the run length. Replaces direct forcing of memory port A.
// PARAMETERS
//  ADDR_W     10    memory address width
//  DATA_W     8     sample width (signed two's complement, passed through unchanged)
//  DEPTH      1024  number of sample locations; at most 2**ADDR_W
//  START_CYC  10    cycles fir_start is held high, >=1
// PORTS
//  clk            in   1        system clock, rising edge
//  rst_n          in   1        synchronous, active-low reset
//  load_req       in   1        1-cycle pulse: begin a load/run sequence (ignored unless IDLE)
//  sel_pipe_in    in   1        filter select, sampled on accepted load_req
//  s_valid        in   1        input sample valid
//  s_ready        out  1        loader can accept a sample
//  s_data         in   DATA_W   input sample
//  s_last         in   1        marks final sample of the block
//  mem_we_a       out  1        memory port A write enable
//  mem_addr_a     out  ADDR_W   memory port A address
//  mem_data_in_a  out  DATA_W   memory port A write data
//  fir_start      out  1        start to fir_top
//  fir_sel_pipe   out  1        sel_pipelined to fir_top, held for the whole run
//  fir_done       in   1        done from fir_top
//  busy           out  1        high in every state except IDLE
//  seq_done       out  1        1-cycle pulse when the sequence completes
//  sample_cnt     out  ADDR_W+1 samples accepted from the stream in the current or last sequence
//  run_cycles     out  32       cycles from fir_start falling to fir_done seen; saturates at 2**32-1
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. sample_cnt, run_cycles and the write pointer are 0.
//  States: IDLE -> LOAD -> [PAD] -> START -> WAIT -> CMPL -> IDLE.
//  IDLE: load_req=1 -> LOAD. Clear sample_cnt, run_cycles and the pointer. Latch sel_pipe_in into fir_sel_pipe.
//  LOAD: s_ready=1 while the pointer < DEPTH. A transfer occurs when s_valid & s_ready in the same cycle.
//   - Write is registered. The cycle after a transfer has mem_we_a=1, mem_addr_a=pointer, mem_data_in_a=s_data.
//   - The pointer and sample_cnt increment by 1 per transfer.
//   - If no transfer occurs, mem_we_a=0 in the next cycle.
//   - A transfer with s_last, or the transfer that makes the pointer = DEPTH, ends LOAD.
//     s_ready drops in the following cycle. The next state is PAD (or START if the pointer = DEPTH).
//   - s_valid with s_ready=0 is not accepted; s_data is not sampled.
//  PAD: writes 0 to the addresses from the pointer to DEPTH-1, one per cycle, with mem_we_a=1.
//   Skipped when the pointer already = DEPTH. sample_cnt does not change.
//  START: fir_start=1 for exactly START_CYC cycles with mem_we_a=0, then WAIT.
//  WAIT: run_cycles increments each cycle until fir_done=1. On fir_done=1 go to CMPL.
//   A fir_done already high on entry counts as done after 1 cycle.
//  CMPL: seq_done=1 for one cycle, then IDLE. sample_cnt and run_cycles hold until the next load_req.
//  load_req outside IDLE is ignored.
//  fir_sel_pipe changes only on an accepted load_req.
//  rst_n=0 in any state aborts the sequence on the next edge:
//   outputs return to reset values and no further memory write is issued.
//  No combinational path from s_valid to s_ready.
// CONFIGURATION
//  ZERO_PAD_EN defined: the PAD state exists as above. Stale samples from an earlier block never reach the filter.
//  ZERO_PAD_EN undefined: no PAD state. LOAD goes directly to START and addresses >= the pointer keep old contents.
// TESTING
//  1. Reset with rst_n=0 for 3 cycles -> every output 0, s_ready=0, busy=0.
//  2. load_req, sel_pipe_in=0, then stream 64,64,64,64,64 (s_last on the 5th) with s_valid held high:
//     -> writes to addr 0..4, data 64, sample_cnt=5.
//     With ZERO_PAD_EN, addr 5..1023 are written with 0 (1019 writes).
//     fir_start is high for 10 cycles and fir_sel_pipe=0.
//  3. Stream with s_valid toggling 1,0,1,0 over 4 samples -> exactly 4 writes at addr 0..3 and no duplicate writes.
//  4. Stream 1030 samples without s_last -> 1024 accepted, s_ready=0 after the 1024th, sample_cnt=1024,
//     no PAD, fir_start follows.
//  5. fir_done model asserts 37 cycles after fir_start falls -> run_cycles=37, one seq_done pulse,
//     fir_sel_pipe=1 when sel_pipe_in=1 was latched.
//  6. rst_n=0 mid-LOAD after 3 samples -> the next cycle has mem_we_a=0, busy=0, sample_cnt=0.
//     A load_req pulse after that starts cleanly at addr 0.

Source files
------------

// File: rtl/fir_sample_loader.sv
// Writer side of the FIR sample memory: streams samples into port A, optionally zero-pads, then runs fir_top.
// Optional feature macro: ZERO_PAD_EN adds the PAD state that clears addresses above the last sample.
module fir_sample_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int START_CYC = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              sel_pipe_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              mem_we_a,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [DATA_W-1:0] mem_data_in_a,
  output logic              fir_start,
  output logic              fir_sel_pipe,
  input  logic              fir_done,
  output logic              busy,
  output logic              seq_done,
  output logic [ADDR_W:0]   sample_cnt,
  output logic [31:0]       run_cycles,
  output logic [2:0]        state_dbg
);

  // Stream handshake: a sample moves on a rising edge where s_valid and s_ready are both high.
  // s_ready is a register, so it never depends combinationally on s_valid.
  typedef enum logic [2:0] {IDLE, LOAD, PAD, START, WAIT, CMPL} state_t;

  localparam int              SC_W     = $clog2(START_CYC + 1);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] ptr;
  logic [SC_W-1:0] start_cnt;
  logic            xfer;
  logic            xfer_end;

  assign xfer      = s_valid & s_ready;
  assign xfer_end  = s_last | (ptr == LAST_PTR);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      start_cnt     <= '0;
      s_ready       <= 1'b0;
      mem_we_a      <= 1'b0;
      mem_addr_a    <= '0;
      mem_data_in_a <= '0;
      fir_start     <= 1'b0;
      fir_sel_pipe  <= 1'b0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      sample_cnt    <= '0;
      run_cycles    <= '0;
    end else begin
      mem_we_a <= 1'b0;
      seq_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_req) begin
            state        <= LOAD;
            ptr          <= '0;
            sample_cnt   <= '0;
            run_cycles   <= '0;
            fir_sel_pipe <= sel_pipe_in;
            s_ready      <= 1'b1;
            busy         <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            mem_we_a      <= 1'b1;
            mem_addr_a    <= ptr[ADDR_W-1:0];
            mem_data_in_a <= s_data;
            ptr           <= ptr + 1'b1;
            sample_cnt    <= sample_cnt + 1'b1;
            if (xfer_end) begin
              s_ready   <= 1'b0;
              start_cnt <= '0;
`ifdef ZERO_PAD_EN
              state     <= (ptr == LAST_PTR) ? START : PAD;
`else
              state     <= START;
`endif
            end
          end
        end
`ifdef ZERO_PAD_EN
        PAD: begin
          mem_we_a      <= 1'b1;
          mem_addr_a    <= ptr[ADDR_W-1:0];
          mem_data_in_a <= '0;
          ptr           <= ptr + 1'b1;
          if (ptr == LAST_PTR) begin
            state     <= START;
            start_cnt <= '0;
          end
        end
`endif
        // First START cycle still shows the final write; fir_start rises one cycle later.
        START: begin
          if (start_cnt < SC_W'(START_CYC)) begin
            fir_start <= 1'b1;
            start_cnt <= start_cnt + 1'b1;
          end else begin
            fir_start <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
          if (fir_done) begin
            state    <= CMPL;
            seq_done <= 1'b1;
          end
        end
        CMPL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_loader.sv
// Randomized bench for fir_sample_loader: stream model, write scoreboard and fir_done responder.
module tb_fir_sample_loader;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 1024;
  localparam int START_CYC = 10;
  localparam int W         = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n, load_req, sel_pipe_in, s_valid, s_last, fir_done;
  logic [DATA_W-1:0] s_data;
  logic              s_ready, mem_we_a, fir_start, fir_sel_pipe, busy, seq_done;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_data_in_a;
  logic [ADDR_W:0]   sample_cnt;
  logic [31:0]       run_cycles;
  logic [2:0]        state_dbg;

  fir_sample_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .START_CYC(START_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .sel_pipe_in(sel_pipe_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a), .mem_data_in_a(mem_data_in_a),
    .fir_start(fir_start), .fir_sel_pipe(fir_sel_pipe), .fir_done(fir_done),
    .busy(busy), .seq_done(seq_done), .sample_cnt(sample_cnt), .run_cycles(run_cycles),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Model state written by the driver at each falling edge, read by the monitor 1 time unit later.
  logic m_ready = 1'b0;
  logic m_sel   = 1'b0;
  int   m_cnt   = 0;
  int   m_delay = 1;
  bit   mon_en  = 0;
  int   seq_cnt = 0;
  int   wr_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process
  logic [W-1:0] e;
  bit fs_prev = 0, sd_prev = 0;
  int fs_cnt = 0;
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk("s_ready", s_ready, m_ready);
      if (mem_we_a === 1'b1) begin
        wr_cnt++;
        chk("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_addr_data", {mem_addr_a, mem_data_in_a}, e);
        end
        chk("no_start_during_write", fir_start, 0);
        chk("busy_during_write", busy, 1);
      end
      if (fir_start === 1'b1 && !fs_prev) chk("writes_done_at_start", exp_q.size(), 0);
      if (fir_start === 1'b1) fs_cnt++;
      if (fs_prev && fir_start === 1'b0) begin
        chk("start_len", fs_cnt, START_CYC);
        fs_cnt = 0;
      end
      if (busy === 1'b1) chk("sel_pipe", fir_sel_pipe, m_sel);
      if (sd_prev) chk("idle_after_done", {busy, seq_done}, 0);
      if (seq_done === 1'b1) begin
        chk("sample_cnt", sample_cnt, m_cnt);
        chk("run_cycles", run_cycles, m_delay);
        chk("busy_at_done", busy, 1);
        seq_cnt++;
      end
      fs_prev = (fir_start === 1'b1);
      sd_prev = (seq_done === 1'b1);
    end
  end

  // fir_top stand-in: done becomes visible in the m_delay-th cycle after fir_start falls.
  initial begin
    bit armed, prev;
    int cnt;
    fir_done = 1'b0;
    armed = 0; prev = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (prev && fir_start === 1'b0) begin
        armed = 1;
        cnt = 1;
      end else if (armed) cnt++;
      if (armed && cnt >= m_delay) fir_done = 1'b1;
      if (seq_done === 1'b1) begin
        fir_done = 1'b0;
        armed = 0;
      end
      prev = (fir_start === 1'b1);
    end
  end

  task automatic start_load(input bit sel);
    @(negedge clk);
    m_ready = 1'b0;
    load_req = 1'b1;
    sel_pipe_in = sel;
    m_sel = sel;
    m_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    load_req = 1'b0;
    sel_pipe_in = ~sel;
  endtask

  // mode 0: valid always high, 1: alternating, 2: random ~70 %
  task automatic run_seq(input int n, input bit use_last, input int mode, input bit sel,
                         input int dly, input bit rnd, input logic [DATA_W-1:0] fixed);
    int k, idx, seq0, waited;
    bit ended;
    k = 0; idx = 0; ended = 0;
    seq0 = seq_cnt;
    m_delay = dly;
    start_load(sel);
    while (!ended) begin
      m_ready = 1'b1;
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (idx % 2 == 0) : ($urandom_range(0, 99) < 70);
      s_data  = rnd ? DATA_W'($urandom) : fixed;
      s_last  = use_last && (k == n - 1);
      if (s_valid) begin
        exp_q.push_back({ADDR_W'(k), s_data});
        k++;
        m_cnt = k;
        if (s_last || k == DEPTH) begin
          ended = 1;
`ifdef ZERO_PAD_EN
          for (int a = k; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), {DATA_W{1'b0}}});
`endif
        end
      end
      idx++;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = DATA_W'($urandom);
      s_last  = 1'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    waited = 0;
    while (seq_cnt == seq0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("seq_done_within_budget", seq_cnt > seq0, 1);
    repeat (3) @(negedge clk);
    chk("one_seq_done_pulse", seq_cnt - seq0, 1);
  endtask

  int exp_wr;
  initial begin
    rst_n = 1'b0; load_req = 1'b0; sel_pipe_in = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we_a, 0);
    chk("rst_addr_data", {mem_addr_a, mem_data_in_a}, 0);
    chk("rst_start_sel", {fir_start, fir_sel_pipe}, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_run_cycles", run_cycles, 0);
    rst_n = 1'b1;
    mon_en = 1;

    // Five samples of 64 with s_last on the fifth
    run_seq(5, 1, 0, 0, 20, 0, 8'd64);
`ifdef ZERO_PAD_EN
    exp_wr = 1024;
`else
    exp_wr = 5;
`endif
    chk("t2_sample_cnt", sample_cnt, 5);
    chk("t2_write_count", wr_cnt, exp_wr);
    chk("t2_sel_pipe", fir_sel_pipe, 0);

    // Valid toggling 1,0,1,0 over four samples
    run_seq(4, 1, 1, 0, 5, 1, '0);
`ifdef ZERO_PAD_EN
    exp_wr = 1024;
`else
    exp_wr = 4;
`endif
    chk("t3_write_count", wr_cnt, exp_wr);

    // 1030 offered without s_last: capped at DEPTH
    run_seq(1030, 0, 0, 0, 8, 1, '0);
    chk("t4_sample_cnt", sample_cnt, 1024);
    chk("t4_write_count", wr_cnt, 1024);

    // Run length and filter select
    run_seq(6, 1, 2, 1, 37, 1, '0);
    chk("t5_run_cycles", run_cycles, 37);
    chk("t5_sel_pipe", fir_sel_pipe, 1);

    // Reset in the middle of LOAD after three samples
    start_load(1);
    for (int i = 0; i < 3; i++) begin
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = DATA_W'($urandom);
      exp_q.push_back({ADDR_W'(i), s_data});
      @(negedge clk);
    end
    m_ready = 1'b1;
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("abort_we", mem_we_a, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sample_cnt", sample_cnt, 0);
    chk("abort_queue_drained", exp_q.size(), 0);
    rst_n = 1'b1;
    run_seq(3, 1, 0, 0, 1, 1, '0);
    chk("restart_sample_cnt", sample_cnt, 3);
    chk("restart_run_cycles", run_cycles, 1);

    for (int r = 0; r < 6; r++)
      run_seq($urandom_range(1, 40), 1, 2, 1'($urandom), $urandom_range(1, 50), 1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
